// File: rtl/array_scan_controller_pkg.sv
// Shared helpers and FSM encoding for the array scan controller.
package array_scan_controller_pkg;

  // Number of bits needed to represent value (0 for value == 0).
  function automatic int unsigned log2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/array_scan_controller_group_element_counter.sv
// Address / element-in-group / group counters for one array scan.
module group_element_counter
  import array_scan_controller_pkg::*;
#(
  parameter int unsigned DIM = 4,
  parameter int unsigned MAX = 8,
  localparam int unsigned ADDR_W = log2(MAX - 1),
  localparam int unsigned ELEM_W = log2(DIM - 1),
  localparam int unsigned GRP_W  = log2(MAX / DIM - 1) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ELEM_W-1:0] elem,
  output logic [GRP_W-1:0]  group,
  output logic              is_last_elem,
  output logic              is_last_addr
);

  localparam int unsigned NumGroups = MAX / DIM;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic [GRP_W-1:0]  group_q, group_d;
  logic              is_last_group;

  assign is_last_elem  = (elem_q == ELEM_W'(DIM - 1));
  assign is_last_addr  = (addr_q == ADDR_W'(MAX - 1));
  assign is_last_group = (group_q == GRP_W'(NumGroups - 1));

  assign addr  = addr_q;
  assign elem  = elem_q;
  assign group = group_q;

  // Next counter values: clear wins, otherwise step on each issued element.
  always_comb begin
    addr_d  = addr_q;
    elem_d  = elem_q;
    group_d = group_q;
    if (clear) begin
      addr_d  = '0;
      elem_d  = '0;
      group_d = '0;
    end else if (advance) begin
      addr_d = is_last_addr ? '0 : addr_q + ADDR_W'(1);
      elem_d = is_last_elem ? '0 : elem_q + ELEM_W'(1);
      if (is_last_elem) begin
        group_d = is_last_group ? '0 : group_q + GRP_W'(1);
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q  <= '0;
      elem_q  <= '0;
      group_q <= '0;
    end else begin
      addr_q  <= addr_d;
      elem_q  <= elem_d;
      group_q <= group_d;
    end
  end

endmodule

// File: rtl/array_scan_controller.sv
// Scan sequencer: issues one array read per cycle and tags the returning data.
module array_scan_controller
  import array_scan_controller_pkg::*;
#(
  parameter int unsigned DIM = 4,
  parameter int unsigned MAX = 8,
  localparam int unsigned ADDR_W = log2(MAX - 1),
  localparam int unsigned GRP_W  = log2(MAX / DIM - 1) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              elem_valid,
  output logic              last_elem,
  output logic              last_group,
  output logic [GRP_W-1:0]  group_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ELEM_W = log2(DIM - 1);

  state_e            state_q, state_d;
  logic              clear, done_set;
  logic [ELEM_W-1:0] elem;
  logic [GRP_W-1:0]  group;
  logic              is_last_elem, is_last_addr;

  group_element_counter #(
    .DIM(DIM),
    .MAX(MAX)
  ) u_counter (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .advance     (mem_rd_en),
    .addr        (mem_addr),
    .elem        (elem),
    .group       (group),
    .is_last_elem(is_last_elem),
    .is_last_addr(is_last_addr)
  );

  // Element index always tracks the address position within its group.
  elem_tracks_addr: assert property (@(posedge clock) disable iff (!reset)
    int'(elem) == int'(mem_addr) % int'(DIM));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state: abort beats hold and the final issue; start only matters in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan: begin
        if (abort)                          state_d = StIdle;
        else if (mem_rd_en && is_last_addr) state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mem_rd_en = (state_q == StScan) && !hold && !abort;
    busy      = (state_q != StIdle);
    clear     = (state_q == StIdle) && start;
    done_set  = (state_q == StDrain) && !abort;
  end

  // Tags delayed one stage so they line up with the memory read data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      elem_valid <= 1'b0;
      last_elem  <= 1'b0;
      last_group <= 1'b0;
      group_idx  <= '0;
      done       <= 1'b0;
    end else begin
      elem_valid <= mem_rd_en;
      last_elem  <= mem_rd_en && is_last_elem;
      last_group <= mem_rd_en && (group == GRP_W'(MAX / DIM - 1));
      group_idx  <= group;
      done       <= done_set;
    end
  end

endmodule

// File: tb/tb_array_scan_controller.sv
// Self-checking bench for array_scan_controller (DIM=4/MAX=8 and DIM=MAX=4).
module tb_array_scan_controller;

  typedef struct {
    int le;
    int lg;
    int grp;
  } tag_t;

  logic clock = 1'b0;
  logic reset, start, start_b, abort, hold;

  logic [2:0] mem_addr_a;
  logic       rd_a, val_a, le_a, lg_a, busy_a, done_a;
  logic [1:0] grp_a;

  logic [1:0] mem_addr_b;
  logic       rd_b, val_b, le_b, lg_b, busy_b, done_b;
  logic [0:0] grp_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  tag_t exp_q[$];
  int   iss_q[$];

  always #5 clock = ~clock;

  array_scan_controller #(.DIM(4), .MAX(8)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .mem_addr(mem_addr_a), .mem_rd_en(rd_a), .elem_valid(val_a), .last_elem(le_a),
    .last_group(lg_a), .group_idx(grp_a), .busy(busy_a), .done(done_a)
  );

  array_scan_controller #(.DIM(4), .MAX(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort), .hold(hold),
    .mem_addr(mem_addr_b), .mem_rd_en(rd_b), .elem_valid(val_b), .last_elem(le_b),
    .last_group(lg_b), .group_idx(grp_b), .busy(busy_b), .done(done_b)
  );

  function automatic bit inr(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Expected issue addresses and tags for the first n_iss / n_tag elements of a scan.
  task automatic push_scan(input int dim, input int max, input int n_iss, input int n_tag);
    tag_t e;
    for (int i = 0; i < n_iss; i++) iss_q.push_back(i);
    for (int i = 0; i < n_tag; i++) begin
      e.le  = ((i % dim) == dim - 1) ? 1 : 0;
      e.grp = i / dim;
      e.lg  = ((i / dim) == (max / dim - 1)) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start_b = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({mem_addr_a, rd_a, val_a, le_a, lg_a, grp_a, busy_a, done_a} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 0",
               {mem_addr_a, rd_a, val_a, le_a, lg_a, grp_a, busy_a, done_a});
    end
    n_checks++;
    if ({mem_addr_b, rd_b, val_b, le_b, lg_b, grp_b, busy_b, done_b} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b want 0",
               {mem_addr_b, rd_b, val_b, le_b, lg_b, grp_b, busy_b, done_b});
    end
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
  endtask

  // Full scan, with a stray start pulse mid-scan that must be ignored.
  task automatic test_basic(input string name);
    tag_t e;
    int   a;
    logic [3:0] ctl;
    push_scan(4, 8, 8, 8);
    @(posedge clock); #1 start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clock); #1 start = (cyc == 4);
      @(negedge clock);
      ctl = {inr(cyc, 1, 8), inr(cyc, 2, 9), cyc == 10, inr(cyc, 1, 9)};
      n_checks++;
      if ({rd_a, val_a, done_a, busy_a} !== ctl) begin
        n_fail++;
        $display("FAIL %s ctl cyc %0d: got %b want %b", name, cyc,
                 {rd_a, val_a, done_a, busy_a}, ctl);
      end
      if (rd_a === 1'b1) begin
        n_checks++;
        if (iss_q.size() == 0) begin
          n_fail++; $display("FAIL %s addr cyc %0d: got issue want none", name, cyc);
        end else begin
          a = iss_q.pop_front();
          if (mem_addr_a !== 3'(a)) begin
            n_fail++; $display("FAIL %s addr cyc %0d: got %0d want %0d", name, cyc, mem_addr_a, a);
          end
        end
      end
      if (val_a === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({le_a, lg_a, grp_a} !== {1'(e.le), 1'(e.lg), 2'(e.grp)}) begin
          n_fail++;
          $display("FAIL %s tag cyc %0d: got %b want %b", name, cyc, {le_a, lg_a, grp_a},
                   {1'(e.le), 1'(e.lg), 2'(e.grp)});
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s leftover: got %0d/%0d want 0/0", name, iss_q.size(), exp_q.size());
      exp_q.delete(); iss_q.delete();
    end
  endtask

  task automatic test_hold();
    tag_t e;
    int   a;
    logic [3:0] ctl;
    push_scan(4, 8, 8, 8);
    @(posedge clock); #1 start = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(posedge clock); #1 start = 1'b0; hold = inr(cyc, 3, 4);
      @(negedge clock);
      ctl = {inr(cyc, 1, 10) && !inr(cyc, 3, 4), inr(cyc, 2, 11) && !inr(cyc, 4, 5),
             cyc == 12, inr(cyc, 1, 11)};
      n_checks++;
      if ({rd_a, val_a, done_a, busy_a} !== ctl) begin
        n_fail++;
        $display("FAIL hold ctl cyc %0d: got %b want %b", cyc, {rd_a, val_a, done_a, busy_a}, ctl);
      end
      if (inr(cyc, 3, 4)) begin
        n_checks++;
        if (mem_addr_a !== 3'd2) begin
          n_fail++; $display("FAIL hold addr_stable cyc %0d: got %0d want 2", cyc, mem_addr_a);
        end
      end
      if (rd_a === 1'b1 && iss_q.size() != 0) begin
        a = iss_q.pop_front();
        n_checks++;
        if (mem_addr_a !== 3'(a)) begin
          n_fail++; $display("FAIL hold addr cyc %0d: got %0d want %0d", cyc, mem_addr_a, a);
        end
      end
      if (val_a === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({le_a, lg_a, grp_a} !== {1'(e.le), 1'(e.lg), 2'(e.grp)}) begin
          n_fail++;
          $display("FAIL hold tag cyc %0d: got %b want %b", cyc, {le_a, lg_a, grp_a},
                   {1'(e.le), 1'(e.lg), 2'(e.grp)});
        end
      end
    end
    hold = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold leftover: got %0d/%0d want 0/0", iss_q.size(), exp_q.size());
      exp_q.delete(); iss_q.delete();
    end
  endtask

  // mid = 0: abort in cycle 5.  mid = 1: reset low in cycle 4.
  task automatic test_cancel(input bit mid);
    tag_t e;
    int   a;
    logic [3:0] ctl;
    int   last_val;
    last_val = mid ? 4 : 5;
    push_scan(4, 8, 4, mid ? 3 : 4);
    @(posedge clock); #1 start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clock); #1 start = 1'b0;
      abort = !mid && (cyc == 5);
      reset = !(mid && (cyc == 4));
      @(negedge clock);
      ctl = {inr(cyc, 1, 4), inr(cyc, 2, last_val), 1'b0, inr(cyc, 1, last_val)};
      n_checks++;
      if ({rd_a, val_a, done_a, busy_a} !== ctl) begin
        n_fail++;
        $display("FAIL cancel%0d ctl cyc %0d: got %b want %b", mid, cyc,
                 {rd_a, val_a, done_a, busy_a}, ctl);
      end
      if (mid && cyc == 5) begin
        n_checks++;
        if ({mem_addr_a, rd_a, val_a, le_a, lg_a, grp_a, busy_a, done_a} !== 11'b0) begin
          n_fail++;
          $display("FAIL cancel_reset_values: got %b want 0",
                   {mem_addr_a, rd_a, val_a, le_a, lg_a, grp_a, busy_a, done_a});
        end
      end
      if (rd_a === 1'b1 && iss_q.size() != 0) begin
        a = iss_q.pop_front();
        n_checks++;
        if (mem_addr_a !== 3'(a)) begin
          n_fail++;
          $display("FAIL cancel%0d addr cyc %0d: got %0d want %0d", mid, cyc, mem_addr_a, a);
        end
      end
      if (val_a === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({le_a, lg_a, grp_a} !== {1'(e.le), 1'(e.lg), 2'(e.grp)}) begin
          n_fail++;
          $display("FAIL cancel%0d tag cyc %0d: got %b want %b", mid, cyc, {le_a, lg_a, grp_a},
                   {1'(e.le), 1'(e.lg), 2'(e.grp)});
        end
      end
    end
    abort = 1'b0; reset = 1'b1;
    n_checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL cancel%0d leftover: got %0d/%0d want 0/0", mid, iss_q.size(), exp_q.size());
      exp_q.delete(); iss_q.delete();
    end
    test_basic(mid ? "rescan_after_reset" : "rescan_after_abort");
  endtask

  // start held high: two scans back to back, second starting the cycle after done.
  task automatic test_back_to_back();
    tag_t e;
    int   a;
    logic [3:0] ctl;
    push_scan(4, 8, 8, 8);
    push_scan(4, 8, 8, 8);
    @(posedge clock); #1 start = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(posedge clock); #1 start = (cyc < 20);
      @(negedge clock);
      ctl = {inr(cyc, 1, 8) || inr(cyc, 11, 18), inr(cyc, 2, 9) || inr(cyc, 12, 19),
             cyc == 10 || cyc == 20, inr(cyc, 1, 9) || inr(cyc, 11, 19)};
      n_checks++;
      if ({rd_a, val_a, done_a, busy_a} !== ctl) begin
        n_fail++;
        $display("FAIL b2b ctl cyc %0d: got %b want %b", cyc, {rd_a, val_a, done_a, busy_a}, ctl);
      end
      if (rd_a === 1'b1 && iss_q.size() != 0) begin
        a = iss_q.pop_front();
        n_checks++;
        if (mem_addr_a !== 3'(a)) begin
          n_fail++; $display("FAIL b2b addr cyc %0d: got %0d want %0d", cyc, mem_addr_a, a);
        end
      end
      if (val_a === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({le_a, lg_a, grp_a} !== {1'(e.le), 1'(e.lg), 2'(e.grp)}) begin
          n_fail++;
          $display("FAIL b2b tag cyc %0d: got %b want %b", cyc, {le_a, lg_a, grp_a},
                   {1'(e.le), 1'(e.lg), 2'(e.grp)});
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b leftover: got %0d/%0d want 0/0", iss_q.size(), exp_q.size());
      exp_q.delete(); iss_q.delete();
    end
  endtask

  // DIM == MAX: one group, every valid element is in the last group.
  task automatic test_single_group();
    tag_t e;
    int   a;
    logic [3:0] ctl;
    push_scan(4, 4, 4, 4);
    @(posedge clock); #1 start_b = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clock); #1 start_b = 1'b0;
      @(negedge clock);
      ctl = {inr(cyc, 1, 4), inr(cyc, 2, 5), cyc == 6, inr(cyc, 1, 5)};
      n_checks++;
      if ({rd_b, val_b, done_b, busy_b} !== ctl) begin
        n_fail++;
        $display("FAIL single ctl cyc %0d: got %b want %b", cyc, {rd_b, val_b, done_b, busy_b}, ctl);
      end
      if (rd_b === 1'b1 && iss_q.size() != 0) begin
        a = iss_q.pop_front();
        n_checks++;
        if (mem_addr_b !== 2'(a)) begin
          n_fail++; $display("FAIL single addr cyc %0d: got %0d want %0d", cyc, mem_addr_b, a);
        end
      end
      if (val_b === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({le_b, lg_b, grp_b} !== {1'(e.le), 1'(e.lg), 1'(e.grp)}) begin
          n_fail++;
          $display("FAIL single tag cyc %0d: got %b want %b", cyc, {le_b, lg_b, grp_b},
                   {1'(e.le), 1'(e.lg), 1'(e.grp)});
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL single leftover: got %0d/%0d want 0/0", iss_q.size(), exp_q.size());
      exp_q.delete(); iss_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_hold();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_back_to_back();
    test_single_group();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
